rnn_char_sequencer: RTL and testbench

Upstream feeder for the `rnn` accelerator core. It accepts a stream of character indices and looks each one up in an internal embedding table. For each character it acts as a bus master on the rnn's register port: it writes the 2-element embedding, starts one recurrent step and polls for completion. After the last character it triggers the dense layer and returns the 16-bit result to the host.

---
 rtl/rnn_char_sequencer_if.sv | 14 +
 rtl/rnn_char_sequencer.sv | 88 ++++++++
 tb/tb_rnn_char_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rnn_char_sequencer_if.sv
// rnn_char_sequencer_if: register-port bus between the sequencer and the rnn core.
// Ports (signals):
//   write  strobe, master->slave     read   strobe, master->slave
//   addr   32-bit register address   wdata  32-bit write data
//   rdata  32-bit read data, slave->master, valid the cycle after read
interface rnn_char_sequencer_if;
    logic        write;
    logic        read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output write, read, addr, wdata, input rdata);
    modport slave  (input write, read, addr, wdata, output rdata);
endinterface

// File: rtl/rnn_char_sequencer.sv
// rnn_char_sequencer: feeds embedded characters into an rnn core and returns its dense result.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   char_valid/ready/data/last         character stream from the host
//   tab_write/addr/data                embedding-table write port, addr = {index, element}
//   rnn                                register-port bus master towards the rnn
//   busy, result, result_valid         status and dense-layer output to the host
module rnn_char_sequencer #(
    parameter int VOCAB  = 64,
    parameter int IDX_W  = 6,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                char_valid,
    output logic                char_ready,
    input  logic [IDX_W-1:0]    char_data,
    input  logic                char_last,
    input  logic                tab_write,
    input  logic [IDX_W:0]      tab_addr,
    input  logic [DATA_W-1:0]   tab_data,
    rnn_char_sequencer_if.master rnn,
    output logic                busy,
    output logic [DATA_W-1:0]   result,
    output logic                result_valid
);
    typedef enum logic [3:0] {IDLE, EMB0, EMB1, STEP, POLL, CHK, DENSE, DPOLL, DCHK, RES, RCAP} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] tab [VOCAB*2];
    logic [DATA_W-1:0] e0, e1;
    logic last, accept, unused_rdata;
    assign char_ready   = state == IDLE;
    assign busy         = !char_ready;
    assign accept       = char_valid && char_ready;
    assign unused_rdata = ^rnn.rdata[31:DATA_W];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VOCAB*2; i++) tab[i] <= '0;
        end else if (tab_write) begin
            tab[tab_addr] <= tab_data;
        end
    end
    // Elements are captured from the pre-write table contents, so a write in the
    // acceptance cycle only affects later lookups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            e0           <= '0;
            e1           <= '0;
            last         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                e0           <= tab[{char_data, 1'b0}];
                e1           <= tab[{char_data, 1'b1}];
                last         <= char_last;
                result_valid <= 1'b0;
            end
            if (state == RCAP) begin
                result       <= rnn.rdata[DATA_W-1:0];
                result_valid <= 1'b1;
            end
        end
    end
    always_comb begin
        state_nx  = state;
        rnn.write = 1'b0;
        rnn.read  = 1'b0;
        rnn.addr  = '0;
        rnn.wdata = '0;
        case (state)
            IDLE:  state_nx = accept ? EMB0 : IDLE;
            EMB0:  begin rnn.write = 1'b1; rnn.addr = 32'd1; rnn.wdata = {16'd0, e0}; state_nx = EMB1; end
            EMB1:  begin rnn.write = 1'b1; rnn.addr = 32'd1; rnn.wdata = {16'd1, e1}; state_nx = STEP; end
            STEP:  begin rnn.write = 1'b1; state_nx = POLL; end
            POLL:  begin rnn.read = 1'b1; state_nx = CHK; end
            CHK:   state_nx = !rnn.rdata[0] ? POLL : last ? DENSE : IDLE;
            DENSE: begin rnn.write = 1'b1; rnn.addr = 32'd7; state_nx = DPOLL; end
            DPOLL: begin rnn.read = 1'b1; state_nx = DCHK; end
            DCHK:  state_nx = rnn.rdata[1] ? RES : DPOLL;
            RES:   begin rnn.read = 1'b1; rnn.addr = 32'd7; state_nx = RCAP; end
            RCAP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rnn_char_sequencer.sv
// tb_rnn_char_sequencer: bus-level scoreboard bench with a behavioural rnn register model.
module tb_rnn_char_sequencer;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic        char_valid = 1'b0, char_last = 1'b0, tab_write = 1'b0;
    logic        char_ready, busy, result_valid;
    logic [5:0]  char_data = '0;
    logic [6:0]  tab_addr = '0;
    logic [15:0] tab_data = '0, result;
    rnn_char_sequencer_if bus();
    rnn_char_sequencer #(.VOCAB(64), .IDX_W(6), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data), .char_last(char_last),
        .tab_write(tab_write), .tab_addr(tab_addr), .tab_data(tab_data),
        .rnn(bus), .busy(busy), .result(result), .result_valid(result_valid)
    );
    int tests = 0, fails = 0, acc_cnt = 0;
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction
    // rnn register model: done bit reported on the Nth poll after a start write
    int polls_need = 1, dpolls_need = 1, pl = 0, dpl = 0;
    logic [15:0] res_val = '0;
    always @(posedge clk) begin
        if (bus.write && bus.addr == 32'd0) pl <= polls_need;
        if (bus.write && bus.addr == 32'd7) dpl <= dpolls_need;
        if (bus.read && bus.addr == 32'd0) begin
            bus.rdata <= {30'd0, dpl == 1, pl == 1};
            if (pl > 0) pl <= pl - 1;
            if (dpl > 0) dpl <= dpl - 1;
        end else if (bus.read && bus.addr == 32'd7) bus.rdata <= {16'hA5A5, res_val};
        else bus.rdata <= $urandom;
    end
    always @(posedge clk) if (rst_n && char_valid && char_ready) acc_cnt++;
    // scoreboard of expected bus strobes
    typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} txn_t;
    txn_t q[$];
    txn_t e;
    always @(negedge clk) begin
        if (bus.write || bus.read) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL bus_extra: got strobe w=%0b r=%0b addr=%0h expected none", bus.write, bus.read, bus.addr);
            end else begin
                e = q.pop_front();
                chk("bus_write", bus.write, e.wr);
                chk("bus_read", bus.read, !e.wr);
                chk("bus_addr", bus.addr, e.addr);
                chk("bus_wdata", bus.wdata, e.data);
            end
        end else begin
            chk("idle_addr", bus.addr, 0);
            chk("idle_wdata", bus.wdata, 0);
        end
    end
    task automatic push_w(input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.wr = 1'b1; t.addr = a; t.data = d;
        q.push_back(t);
    endtask
    task automatic push_r(input logic [31:0] a);
        txn_t t;
        t.wr = 1'b0; t.addr = a; t.data = '0;
        q.push_back(t);
    endtask
    task automatic push_char(input logic [15:0] v0, input logic [15:0] v1, input int polls, input logic l, input int dpolls);
        polls_need = polls;
        dpolls_need = dpolls;
        push_w(32'd1, {16'd0, v0});
        push_w(32'd1, {16'd1, v1});
        push_w(32'd0, 32'd0);
        repeat (polls) push_r(32'd0);
        if (l) begin
            push_w(32'd7, 32'd0);
            repeat (dpolls) push_r(32'd0);
            push_r(32'd7);
        end
    endtask
    task automatic wr_tab(input logic [5:0] i, input logic el, input logic [15:0] v);
        @(negedge clk);
        tab_write = 1'b1; tab_addr = {i, el}; tab_data = v;
        @(posedge clk); #1;
        tab_write = 1'b0;
    endtask
    task automatic send(input logic [5:0] i, input logic l);
        int n = 0;
        @(negedge clk);
        char_data = i; char_last = l; char_valid = 1'b1;
        while (!char_ready && n < 500) begin @(negedge clk); n++; end
        if (!char_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: char_ready=%0b expected 1", char_ready);
        end
        @(posedge clk); #1;
        char_valid = 1'b0;
    endtask
    task automatic wait_idle;
        int n = 0;
        @(negedge clk);
        while (busy && n < 500) begin @(negedge clk); n++; end
        if (busy) begin
            tests++; fails++;
            $display("FAIL idle_timeout: busy=%0b expected 0", busy);
        end
    endtask
    typedef struct {logic [5:0] idx; logic last; logic [15:0] e0; logic [15:0] e1; int polls; int dpolls; logic [15:0] res;} vec_t;
    vec_t vecs[5];
    logic [15:0] exp_res = '0;
    int acc0;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        vecs[0] = '{6'd5,  1'b0, 16'd2,     16'hFFFD, 3, 1, 16'd0};
        vecs[1] = '{6'd9,  1'b1, 16'hFFF8,  16'd3,    1, 2, 16'd17595};
        vecs[2] = '{6'd63, 1'b1, 16'h7FFF,  16'h8000, 2, 1, 16'hBEEF};
        vecs[3] = '{6'd0,  1'b0, 16'd1,     16'd0,    1, 1, 16'd0};
        vecs[4] = '{6'd1,  1'b1, 16'h1111,  16'h2222, 4, 3, 16'h0001};
        @(negedge clk);
        chk("rst_char_ready", char_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_write", bus.write, 0);
        chk("rst_read", bus.read, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // single step: done on the 3rd poll, back in IDLE 9 edges after acceptance
        wr_tab(6'd5, 1'b0, 16'd2);
        wr_tab(6'd5, 1'b1, 16'hFFFD);
        push_char(16'd2, 16'hFFFD, 3, 1'b0, 1);
        send(6'd5, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("step_busy", busy, k < 9);
        end
        chk("step_drain", q.size(), 0);
        chk("step_result_valid", result_valid, 0);
        // table write colliding with acceptance
        push_char(16'd2, 16'hFFFD, 1, 1'b0, 1);
        @(negedge clk);
        char_valid = 1'b1; char_data = 6'd5; char_last = 1'b0;
        tab_write = 1'b1; tab_addr = {6'd5, 1'b0}; tab_data = 16'd7;
        @(posedge clk); #1;
        char_valid = 1'b0; tab_write = 1'b0;
        wait_idle();
        chk("coll_drain", q.size(), 0);
        push_char(16'd7, 16'hFFFD, 1, 1'b0, 1);
        send(6'd5, 1'b0);
        wait_idle();
        chk("coll_later_drain", q.size(), 0);
        // vector table
        for (int i = 0; i < 5; i++) begin
            wr_tab(vecs[i].idx, 1'b0, vecs[i].e0);
            wr_tab(vecs[i].idx, 1'b1, vecs[i].e1);
            res_val = vecs[i].res;
            push_char(vecs[i].e0, vecs[i].e1, vecs[i].polls, vecs[i].last, vecs[i].dpolls);
            send(vecs[i].idx, vecs[i].last);
            wait_idle();
            if (vecs[i].last) exp_res = vecs[i].res;
            chk("vec_result_valid", result_valid, vecs[i].last);
            chk("vec_result", result, exp_res);
            chk("vec_drain", q.size(), 0);
        end
        // back-to-back: result_valid drops after acceptance, result retained
        chk("b2b_pre_valid", result_valid, 1);
        push_char(16'd2, 16'hFFFD, 2, 1'b0, 1);
        send(6'd5, 1'b0);
        @(negedge clk);
        chk("b2b_valid_drop", result_valid, 0);
        chk("b2b_result_kept", result, exp_res);
        wait_idle();
        chk("b2b_result_idle", result, exp_res);
        chk("b2b_drain", q.size(), 0);
        // backpressure: char_valid held through busy, single acceptance
        wr_tab(6'd3, 1'b0, 16'h1234);
        wr_tab(6'd3, 1'b1, 16'h5678);
        push_char(16'h1234, 16'h5678, 2, 1'b0, 1);
        acc0 = acc_cnt;
        @(negedge clk);
        char_valid = 1'b1; char_data = 6'd3; char_last = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            chk("bp_ready", char_ready, !busy);
            if (!busy) break;
        end
        char_valid = 1'b0;
        chk("bp_accepts", acc_cnt - acc0, 1);
        chk("bp_drain", q.size(), 0);
        // reset mid-POLL clears state and table
        push_char(16'h1234, 16'h5678, 100, 1'b0, 1);
        send(6'd3, 1'b0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("rst2_char_ready", char_ready, 1);
        chk("rst2_busy", busy, 0);
        chk("rst2_result", result, 0);
        chk("rst2_result_valid", result_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_char(16'd0, 16'd0, 1, 1'b0, 1);
        send(6'd3, 1'b0);
        wait_idle();
        chk("rst2_table_drain", q.size(), 0);
        repeat (3) @(negedge clk);
        chk("final_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
